// File: rtl/text_console_pkg.sv
// Shared constants, control codes and FSM state type for the text console writer.
package text_console_pkg;
  localparam int unsigned COLS   = 64;
  localparam int unsigned ROWS   = 24;
  localparam int unsigned ADDR_W = 11;
  localparam logic [7:0]  BLANK  = 8'h00;

  localparam logic [7:0] CC_NL = 8'h0A;
  localparam logic [7:0] CC_CR = 8'h0D;
  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_FF = 8'h0C;

  localparam logic [ADDR_W-1:0] LAST_ADDR   = 11'd1535;
  localparam logic [ADDR_W-1:0] SCROLL_LAST = 11'd1471;
  localparam logic [ADDR_W-1:0] FILL_BASE   = 11'd1472;
  localparam logic [ADDR_W-1:0] ROW_STRIDE  = 11'd64;

  localparam logic [5:0] LAST_COL = 6'd63;
  localparam logic [4:0] LAST_ROW = 5'd23;

  typedef enum logic [2:0] {
    IDLE,
    PUT,
    SCROLL_RD,
    SCROLL_WR,
    FILL_ROW,
    CLEAR
  } state_e;
endpackage

// File: rtl/console_mem_sequencer.sv
// Address counter and RAM access sequencing for row-copy scroll and blank fills.
module console_mem_sequencer
  import text_console_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  state_e            state,
  input  logic [7:0]        rdata,
  output logic [ADDR_W-1:0] seq_addr,
  output logic [7:0]        seq_wdata,
  output logic              seq_wren,
  output logic              copy_done,
  output logic              fill_done
);
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d     = cnt_q;
    seq_addr  = cnt_q;
    seq_wdata = BLANK;
    seq_wren  = 1'b0;
    copy_done = (cnt_q == SCROLL_LAST);
    fill_done = (cnt_q == LAST_ADDR);
    case (state)
      SCROLL_RD: seq_addr = cnt_q + ROW_STRIDE;
      SCROLL_WR: begin
        seq_wdata = rdata;
        seq_wren  = 1'b1;
        // Copy finishes on the last row-22 cell; the counter carries straight into the bottom-row fill.
        cnt_d     = copy_done ? FILL_BASE : cnt_q + 11'd1;
      end
      FILL_ROW, CLEAR: begin
        seq_wren = 1'b1;
        cnt_d    = fill_done ? '0 : cnt_q + 11'd1;
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/text_console_writer.sv
// Character/control-code stream to 64x24 text RAM writer with cursor, wrap, scroll and clear.
module text_console_writer
  import text_console_pkg::*;
(
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_wren,
  input  logic [7:0]        mem_rdata,
  output logic [5:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);
  state_e     state_q, state_d;
  logic [5:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic [7:0] char_q, char_d;
  logic       adv_q, adv_d;
  logic       xfer;

  logic [ADDR_W-1:0] seq_addr;
  logic [7:0]        seq_wdata;
  logic              seq_wren, copy_done, fill_done, wren_raw;

  console_mem_sequencer u_seq (
    .clk       (CLOCK_50),
    .reset     (reset),
    .state     (state_q),
    .rdata     (mem_rdata),
    .seq_addr  (seq_addr),
    .seq_wdata (seq_wdata),
    .seq_wren  (seq_wren),
    .copy_done (copy_done),
    .fill_done (fill_done)
  );

  assign char_ready = (state_q == IDLE) && !reset;
  assign xfer       = char_valid && char_ready;
  assign busy       = reset || (state_q != IDLE);
  assign cursor_col = col_q;
  assign cursor_row = row_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    char_d  = char_q;
    adv_d   = adv_q;
    case (state_q)
      IDLE: if (xfer) begin
        case (char_data)
          CC_NL: begin
            col_d = '0;
            if (row_q == LAST_ROW) state_d = SCROLL_RD;
            else                   row_d   = row_q + 5'd1;
          end
          CC_CR: col_d = '0;
          CC_BS: if (col_q != '0) begin
            col_d   = col_q - 6'd1;
            char_d  = BLANK;
            adv_d   = 1'b0;
            state_d = PUT;
          end
          CC_FF: begin
            col_d   = '0;
            row_d   = '0;
            state_d = CLEAR;
          end
          default: begin
            char_d  = char_data;
            adv_d   = 1'b1;
            state_d = PUT;
          end
        endcase
      end
      PUT: begin
        state_d = IDLE;
        // Backspace reuses PUT to blank the cell but must leave the cursor in place.
        if (adv_q) begin
          if (col_q != LAST_COL) begin
            col_d = col_q + 6'd1;
          end else begin
            col_d = '0;
            if (row_q != LAST_ROW) row_d   = row_q + 5'd1;
            else                   state_d = SCROLL_RD;
          end
        end
      end
      SCROLL_RD: state_d = SCROLL_WR;
      SCROLL_WR: state_d = copy_done ? FILL_ROW : SCROLL_RD;
      FILL_ROW, CLEAR: if (fill_done) state_d = IDLE;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    mem_addr  = seq_addr;
    mem_wdata = seq_wdata;
    wren_raw  = seq_wren;
    if (state_q == PUT) begin
      mem_addr  = {row_q, col_q};
      mem_wdata = char_q;
      wren_raw  = 1'b1;
    end
    mem_wren = wren_raw && !reset;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= CLEAR;
      col_q   <= '0;
      row_q   <= '0;
      char_q  <= BLANK;
      adv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      char_q  <= char_d;
      adv_q   <= adv_d;
    end
  end
endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer with a behavioural dual-use text RAM.
module tb_text_console_writer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_ready, mem_wren, busy;
  logic [10:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;

  logic [7:0] ram [0:2047];
  logic       preload = 1'b0;
  int         cnt43 = 0;
  int         checks = 0;
  int         passed = 0;

  typedef struct {
    logic [7:0] c;
    int         wr;
    int         addr;
    int         d;
    int         col;
    int         row;
  } vec_t;
  vec_t tbl [12];

  text_console_writer dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wren   (mem_wren),
    .mem_rdata  (mem_rdata),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 2048; k++) ram[k] <= 8'(k / 64 + 1);
    end else if (mem_wren) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  always @(posedge clk) if (mem_wren && mem_wdata == 8'h43) cnt43 <= cnt43 + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic send(input logic [7:0] c);
    int n = 0;
    while (!char_ready && n < 10000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!char_ready) check("send_ready_timeout", 0, 1);
    char_valid = 1'b1;
    char_data  = c;
    @(posedge clk); #1;
    char_valid = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_cursor(input string name, input int col, input int row);
    check({name, "_col"}, int'(cursor_col), col);
    check({name, "_row"}, int'(cursor_row), row);
  endtask

  task automatic check_clear(input string name);
    int errs = 0;
    for (int i = 0; i < 1536; i++) begin
      if (!(mem_wren && int'(mem_addr) == i && mem_wdata == 8'h00)) errs++;
      @(posedge clk); #1;
    end
    check(name, errs, 0);
    check({name, "_ready"}, int'(char_ready), 1);
    check({name, "_wren_after"}, int'(mem_wren), 0);
    check_cursor(name, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int errs;
    int base43;

    tbl[0]  = '{8'h41, 1, 0,   8'h41, 1, 0};
    tbl[1]  = '{8'h42, 1, 1,   8'h42, 2, 0};
    tbl[2]  = '{8'h0D, 0, 0,   0,     0, 0};
    tbl[3]  = '{8'h08, 0, 0,   0,     0, 0};
    tbl[4]  = '{8'h0A, 0, 0,   0,     0, 1};
    tbl[5]  = '{8'h0A, 0, 0,   0,     0, 2};
    tbl[6]  = '{8'h78, 1, 128, 8'h78, 1, 2};
    tbl[7]  = '{8'h79, 1, 129, 8'h79, 2, 2};
    tbl[8]  = '{8'h7A, 1, 130, 8'h7A, 3, 2};
    tbl[9]  = '{8'h08, 1, 130, 8'h00, 2, 2};
    tbl[10] = '{8'h00, 1, 130, 8'h00, 3, 2};
    tbl[11] = '{8'h0D, 0, 0,   0,     0, 2};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_cursor("rst", 0, 0);
    check("rst_wren", int'(mem_wren), 0);
    check("rst_ready", int'(char_ready), 0);
    check("rst_busy", int'(busy), 1);
    reset = 1'b0;
    #1;
    check_clear("post_reset_clear");

    // Directed character/control vectors
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].c);
      check($sformatf("v%0d_wren", i), int'(mem_wren), tbl[i].wr);
      if (tbl[i].wr != 0) begin
        check($sformatf("v%0d_addr", i), int'(mem_addr), tbl[i].addr);
        check($sformatf("v%0d_data", i), int'(mem_wdata), tbl[i].d);
      end
      count_busy(n);
      check_cursor($sformatf("v%0d", i), tbl[i].col, tbl[i].row);
    end

    // Backpressure: 0x43 held throughout a clear
    send(8'h0C);
    base43 = cnt43;
    char_valid = 1'b1;
    char_data  = 8'h43;
    n = 0;
    while (!char_ready && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_wait_cycles", n, 1536);
    check("bp_no_early_write", cnt43 - base43, 0);
    @(posedge clk); #1;
    char_valid = 1'b0;
    check("bp_wren", int'(mem_wren), 1);
    check("bp_addr", int'(mem_addr), 0);
    check("bp_data", int'(mem_wdata), 8'h43);
    count_busy(n);
    repeat (3) @(posedge clk);
    #1;
    check("bp_write_once", cnt43 - base43, 1);
    check_cursor("bp", 1, 0);

    // Wrap at (63,5) without scroll
    send(8'h0D);
    for (int i = 0; i < 5; i++) send(8'h0A);
    for (int i = 0; i < 63; i++) send(8'h61);
    count_busy(n);
    check_cursor("pre_wrap", 63, 5);
    send(8'h5A);
    check("wrap_addr", int'(mem_addr), 383);
    check("wrap_data", int'(mem_wdata), 8'h5A);
    count_busy(n);
    check("wrap_busy", n, 1);
    check_cursor("wrap", 0, 6);

    // Newline scroll from (5,23)
    for (int i = 0; i < 17; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h61);
    count_busy(n);
    check_cursor("pre_scroll", 5, 23);
    preload = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;
    send(8'h0A);
    check("nl_scroll_first_wren", int'(mem_wren), 0);
    count_busy(n);
    check("nl_scroll_busy", n, 3008);
    check_cursor("nl_scroll", 0, 23);
    errs = 0;
    for (int k = 0; k < 1536; k++) begin
      if (int'(ram[k]) != ((k < 1472) ? (k / 64 + 2) : 0)) errs++;
    end
    check("nl_scroll_ram", errs, 0);

    // Printable at (63,23): last-cell write then scroll
    for (int i = 0; i < 63; i++) send(8'h61);
    count_busy(n);
    check_cursor("pre_lastcell", 63, 23);
    send(8'h51);
    check("lastcell_wren", int'(mem_wren), 1);
    check("lastcell_addr", int'(mem_addr), 1535);
    check("lastcell_data", int'(mem_wdata), 8'h51);
    count_busy(n);
    check("lastcell_busy", n, 3009);
    check_cursor("lastcell", 0, 23);
    check("lastcell_copied", int'(ram[1471]), 8'h51);
    check("lastcell_blanked", int'(ram[1535]), 0);

    // Reset during a scroll
    send(8'h0A);
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_wren", int'(mem_wren), 0);
    check("midrst_ready", int'(char_ready), 0);
    check("midrst_busy", int'(busy), 1);
    errs = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (mem_wren || char_ready || !busy) errs++;
    end
    check("midrst_held", errs, 0);
    check_cursor("midrst", 0, 0);
    reset = 1'b0;
    #1;
    check_clear("midrst_clear");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
